// File: rtl/conv_operand_sequencer_if.sv
// Element and result streams between the convolution operand sequencer and its
// source/sink. The slave side is the sequencer, the master side is the traffic source.
interface conv_operand_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_kernel;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_overflow;

    modport slave (
        input  in_valid, in_data, in_is_kernel, res_ready,
        output in_ready, res_valid, res_data, res_overflow
    );

    modport master (
        output in_valid, in_data, in_is_kernel, res_ready,
        input  in_ready, res_valid, res_data, res_overflow
    );
endinterface

// File: rtl/conv_operand_sequencer.sv
// Packs byte-serial kernel/image elements into the 5x5 convolution ALU operand
// buses, waits for the ALU, and returns its clamped result over a valid/ready channel.
module conv_operand_sequencer #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    conv_operand_sequencer_if.slave   bus,
    input  logic                      kernel_clear,
    output logic [199:0]              a_flat,
    output logic [199:0]              b_flat,
    input  logic [7:0]                alu_result,
    input  logic                      alu_overflow,
    output logic                      busy,
    output logic [CNT_W-1:0]          window_count
);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        RESULT
    } state_t;

    localparam logic [4:0] LAST_IDX  = 5'd24;
    localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);

    state_t     state;
    logic [4:0] k_cnt;
    logic [4:0] i_cnt;
    logic       kernel_full;
    logic       img_full;
    logic [3:0] wait_cnt;

    logic       kernel_beat;
    logic       image_beat;
    logic       kernel_full_nxt;
    logic       img_full_nxt;

    // A clear pulse blocks a simultaneous kernel beat so that beat is never half-accepted.
    assign bus.in_ready = (state == LOAD)
                        & ~(~bus.in_is_kernel & img_full)
                        & ~(bus.in_is_kernel & kernel_clear);

    always_comb begin
        kernel_beat     = bus.in_valid & bus.in_ready & bus.in_is_kernel;
        image_beat      = bus.in_valid & bus.in_ready & ~bus.in_is_kernel;
        kernel_full_nxt = kernel_full;
        if (kernel_clear)
            kernel_full_nxt = 1'b0;
        else if (kernel_beat)
            kernel_full_nxt = ~kernel_full & (k_cnt == LAST_IDX);
        img_full_nxt    = img_full | (image_beat & (i_cnt == LAST_IDX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= LOAD;
            k_cnt            <= '0;
            i_cnt            <= '0;
            kernel_full      <= 1'b0;
            img_full         <= 1'b0;
            wait_cnt         <= '0;
            a_flat           <= '0;
            b_flat           <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_data     <= '0;
            bus.res_overflow <= 1'b0;
            busy             <= 1'b0;
            window_count     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (kernel_clear) begin
                        kernel_full <= 1'b0;
                        k_cnt       <= '0;
                    end else if (kernel_beat) begin
                        a_flat[{k_cnt, 3'b000} +: 8] <= bus.in_data;
                        // A beat arriving on a full kernel restarts it at index 0.
                        if (kernel_full) begin
                            kernel_full <= 1'b0;
                            k_cnt       <= 5'd1;
                        end else if (k_cnt == LAST_IDX) begin
                            kernel_full <= 1'b1;
                            k_cnt       <= '0;
                        end else begin
                            k_cnt <= k_cnt + 5'd1;
                        end
                    end
                    if (image_beat) begin
                        b_flat[{i_cnt, 3'b000} +: 8] <= bus.in_data;
                        if (i_cnt == LAST_IDX) begin
                            img_full <= 1'b1;
                            i_cnt    <= '0;
                        end else begin
                            i_cnt <= i_cnt + 5'd1;
                        end
                    end
                    if (kernel_full_nxt && img_full_nxt) begin
                        state    <= COMPUTE;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                COMPUTE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        bus.res_data     <= alu_result;
                        bus.res_overflow <= alu_overflow;
                        bus.res_valid    <= 1'b1;
                        img_full         <= 1'b0;
                        state            <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        window_count  <= window_count + 1'b1;
                        busy          <= 1'b0;
                        state         <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Randomised self-checking bench for conv_operand_sequencer, with a stand-in
// clamping ALU and a queue-based reference model of the kernel/image buffers.
module tb_conv_operand_sequencer;

    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               kernel_clear;
    logic [199:0]       a_flat;
    logic [199:0]       b_flat;
    logic [7:0]         alu_result;
    logic               alu_overflow;
    logic               busy;
    logic [CNT_W-1:0]   window_count;
    int                 alu_sum;

    conv_operand_sequencer_if bus_if ();

    conv_operand_sequencer #(
        .ALU_LATENCY (ALU_LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if.slave),
        .kernel_clear (kernel_clear),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .window_count (window_count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: dot product of signed bytes, clamped to 0..127 with an overflow flag.
    always_comb begin
        alu_sum = 0;
        for (int i = 0; i < 25; i++)
            alu_sum += int'($signed(a_flat[8*i +: 8])) * int'($signed(b_flat[8*i +: 8]));
        alu_result   = 8'd0;
        alu_overflow = 1'b0;
        if (alu_sum > 127) begin
            alu_result   = 8'd127;
            alu_overflow = 1'b1;
        end else if (alu_sum < 0) begin
            alu_overflow = 1'b1;
        end else begin
            alu_result = 8'(alu_sum);
        end
    end

    int         compare_count  = 0;
    int         mismatch_count = 0;
    logic [7:0] kq[$];
    logic [7:0] iq[$];
    logic [7:0] a_shadow[25];
    logic [7:0] b_shadow[25];
    bit         m_load;
    int         m_windows;

    task automatic check_output(input string tag, input logic [255:0] observed,
                                input logic [255:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [199:0] pack(input logic [7:0] s[25]);
        logic [199:0] v;
        for (int i = 0; i < 25; i++)
            v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic model_reset();
        kq.delete();
        iq.delete();
        for (int i = 0; i < 25; i++) begin
            a_shadow[i] = 8'h00;
            b_shadow[i] = 8'h00;
        end
        m_load    = 1'b1;
        m_windows = 0;
    endtask

    task automatic model_result(output logic [7:0] r, output logic ov);
        int s = 0;
        for (int i = 0; i < 25; i++)
            s += int'($signed(kq[i])) * int'($signed(iq[i]));
        if (s > 127) begin
            r = 8'd127; ov = 1'b1;
        end else if (s < 0) begin
            r = 8'd0; ov = 1'b1;
        end else begin
            r = 8'(s); ov = 1'b0;
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_a_flat", a_flat, 0);
        check_output("rst_b_flat", b_flat, 0);
        check_output("rst_res_valid", bus_if.res_valid, 0);
        check_output("rst_res_data", bus_if.res_data, 0);
        check_output("rst_res_overflow", bus_if.res_overflow, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_window_count", window_count, 0);
    endtask

    // One cycle of element traffic; the model decides whether the beat should land.
    task automatic apply_stimulus(input bit valid, input logic [7:0] data,
                                  input bit is_kernel, input bit clear);
        bit exp_ready;
        bus_if.in_valid     = valid;
        bus_if.in_data      = data;
        bus_if.in_is_kernel = is_kernel;
        kernel_clear        = clear;
        exp_ready = m_load && !(!is_kernel && iq.size() == 25) && !(is_kernel && clear);
        @(negedge clk);
        check_output("in_ready", bus_if.in_ready, exp_ready);
        @(posedge clk);
        #1;
        if (m_load && clear)
            kq.delete();
        if (valid && exp_ready) begin
            if (is_kernel) begin
                if (kq.size() == 25)
                    kq.delete();
                a_shadow[kq.size()] = data;
                kq.push_back(data);
            end else begin
                b_shadow[iq.size()] = data;
                iq.push_back(data);
            end
        end
        if (kq.size() == 25 && iq.size() == 25)
            m_load = 1'b0;
        bus_if.in_valid = 1'b0;
        kernel_clear    = 1'b0;
    endtask

    task automatic load_fill(input bit is_kernel, input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b1, val, is_kernel, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 1) == 0)
            return 8'($urandom_range(0, 6)) - 8'd3;
        return 8'($urandom);
    endfunction

    task automatic load_random(input bit is_kernel, input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b1, rand_byte(), is_kernel, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Waits for the result, checks it against the model, then holds and retires it.
    task automatic collect_result(input int hold, input bit reset_in_result);
        logic [7:0] exp_data;
        logic       exp_ov;
        int         n = 0;
        bus_if.in_valid = 1'b0;
        check_output("busy_compute", busy, 1);
        while (!bus_if.res_valid && n < 4 * ALU_LAT + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("result_latency", 256'(n), 256'(ALU_LAT));
        model_result(exp_data, exp_ov);
        check_output("res_data", bus_if.res_data, exp_data);
        check_output("res_overflow", bus_if.res_overflow, exp_ov);
        check_output("a_flat", a_flat, pack(a_shadow));
        check_output("b_flat", b_flat, pack(b_shadow));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check_output("hold_res_valid", bus_if.res_valid, 1);
            check_output("hold_res_data", bus_if.res_data, exp_data);
            check_output("hold_res_overflow", bus_if.res_overflow, exp_ov);
            check_output("hold_in_ready", bus_if.in_ready, 0);
            check_output("hold_busy", busy, 1);
        end
        if (reset_in_result) begin
            do_reset();
        end else begin
            bus_if.res_ready = 1'b1;
            @(posedge clk);
            #1;
            bus_if.res_ready = 1'b0;
            m_windows = (m_windows + 1) % (1 << CNT_W);
            iq.delete();
            m_load = 1'b1;
            check_output("done_res_valid", bus_if.res_valid, 0);
            check_output("done_busy", busy, 0);
            check_output("window_count", window_count, 256'(m_windows));
        end
    endtask

    task automatic random_window(input bit reload);
        int kleft = reload ? 25 : 0;
        int ileft = 25;
        bit pick;
        while (kleft + ileft > 0) begin
            if ($urandom_range(0, 4) == 0) begin
                apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
            end else begin
                pick = (kleft > 0) && (ileft == 0 || $urandom_range(0, 1) == 1);
                apply_stimulus(1'b1, rand_byte(), pick, 1'b0);
                if (pick) kleft--; else ileft--;
            end
        end
        collect_result($urandom_range(0, 3), 1'b0);
    endtask

    initial begin
        rst_n               = 1'b0;
        kernel_clear        = 1'b0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_data      = 8'h00;
        bus_if.in_is_kernel = 1'b0;
        bus_if.res_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values();

        // Uniform kernel/image windows with known clamped results.
        load_fill(1'b1, 8'h01, 25);
        load_fill(1'b0, 8'h02, 25);
        collect_result(0, 1'b0);
        load_fill(1'b1, 8'h01, 25);
        load_fill(1'b0, 8'h0A, 25);
        collect_result(0, 1'b0);
        load_fill(1'b0, 8'hFF, 25);
        collect_result(0, 1'b0);

        // Back-pressure on the result channel.
        load_random(1'b0, 25);
        collect_result(5, 1'b0);

        // Image first with overrun beats, then a fresh kernel.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        load_random(1'b0, 25);
        load_random(1'b0, 3);
        load_random(1'b1, 25);
        collect_result(1, 1'b0);

        // Partial kernel, clear colliding with a kernel beat, then a new kernel.
        load_random(1'b1, 10);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b1);
        load_random(1'b1, 25);
        load_random(1'b0, 25);
        collect_result(0, 1'b0);

        // Reset mid image load, then reset while a result is pending.
        load_random(1'b1, 25);
        load_random(1'b0, 12);
        do_reset();
        load_random(1'b1, 25);
        load_random(1'b0, 25);
        collect_result(2, 1'b1);

        for (int w = 0; w < 10; w++)
            random_window(w == 0 || $urandom_range(0, 2) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
